// File: rtl/mips_instr_encoder_if.sv
// Operand-bundle input and encoded-word output stream of the MIPS instruction encoder.
// master = producer of operands / consumer of words (loader side); slave = encoder.
// Both directions use valid/ready handshakes.
interface mips_instr_encoder_if;
   logic        in_valid;
   logic        in_ready;
   logic [5:0]  op_id;
   logic [4:0]  rs;
   logic [4:0]  rt;
   logic [4:0]  rd;
   logic [4:0]  shamt;
   logic [15:0] imm;
   logic [25:0] target;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic [31:0] out_addr;

   modport master (
      output in_valid, op_id, rs, rt, rd, shamt, imm, target, out_ready,
      input  in_ready, out_valid, out_instr, out_addr
   );

   modport slave (
      input  in_valid, op_id, rs, rt, rd, shamt, imm, target, out_ready,
      output in_ready, out_valid, out_instr, out_addr
   );
endinterface

// File: rtl/mips_instr_encoder.sv
// Encodes mnemonic ID + operand fields into 32-bit MIPS words, queues them, streams them with byte addresses.
// Latency: one cycle from input accept to head of an empty queue; no combinational input->output path.
// Backpressure: in_ready = !full (no push-through on pop when full); ENC_COUNT_EN adds emit_count output.
module mips_instr_encoder #(
   parameter int          FIFO_DEPTH = 4,
   parameter logic [31:0] BASE_ADDR  = 32'h0000_3000
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 flush,
   mips_instr_encoder_if.slave  bus,
   output logic                 err_illegal,
   output logic [5:0]           err_op
`ifdef ENC_COUNT_EN
   ,
   output logic [31:0]          emit_count
`endif
);

   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = AW + 1;

   logic [31:0]   mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic [31:0]   addr_q;
   logic [31:0]   enc_word;
   logic          enc_legal;
   logic          full;
   logic          empty;
   logic          accept;
   logic          push;
   logic          pop;

   function automatic logic [31:0] r_fmt(input logic [4:0] s, input logic [4:0] t,
                                         input logic [4:0] d, input logic [4:0] sh,
                                         input logic [5:0] fn);
      return {6'd0, s, t, d, sh, fn};
   endfunction

   function automatic logic [31:0] i_fmt(input logic [5:0] op, input logic [4:0] s,
                                         input logic [4:0] t, input logic [15:0] im);
      return {op, s, t, im};
   endfunction

   assign full          = (count == CW'(FIFO_DEPTH));
   assign empty         = (count == '0);
   assign bus.in_ready  = !full;
   assign bus.out_valid = !empty;
   assign bus.out_instr = empty ? 32'h0 : mem[rd_ptr];
   assign bus.out_addr  = addr_q;

   assign accept = bus.in_valid && !full;
   assign push   = accept && enc_legal;
   assign pop    = !empty && bus.out_ready;

   // Map mnemonic ID to its encoding, zeroing every field the instruction does not use.
   always_comb begin
      enc_word  = 32'h0;
      enc_legal = 1'b1;
      case (bus.op_id)
         6'd0:  enc_word = 32'h0;                                             // NOP
         6'd1:  enc_word = r_fmt(5'd0,   bus.rt, bus.rd, bus.shamt, 6'd0);   // SLL
         6'd2:  enc_word = r_fmt(5'd0,   bus.rt, bus.rd, bus.shamt, 6'd2);   // SRL
         6'd3:  enc_word = r_fmt(5'd0,   bus.rt, bus.rd, bus.shamt, 6'd3);   // SRA
         6'd4:  enc_word = r_fmt(bus.rs, bus.rt, bus.rd, 5'd0, 6'd4);        // SLLV
         6'd5:  enc_word = r_fmt(bus.rs, bus.rt, bus.rd, 5'd0, 6'd6);        // SRLV
         6'd6:  enc_word = r_fmt(bus.rs, bus.rt, bus.rd, 5'd0, 6'd7);        // SRAV
         6'd7:  enc_word = r_fmt(bus.rs, 5'd0,   5'd0,   5'd0, 6'd8);        // JR
         6'd8:  enc_word = r_fmt(bus.rs, 5'd0,   bus.rd, 5'd0, 6'd9);        // JALR
         6'd9:  enc_word = r_fmt(bus.rs, bus.rt, bus.rd, 5'd0, 6'd32);       // ADD
         6'd10: enc_word = r_fmt(bus.rs, bus.rt, bus.rd, 5'd0, 6'd33);       // ADDU
         6'd11: enc_word = r_fmt(bus.rs, bus.rt, bus.rd, 5'd0, 6'd34);       // SUB
         6'd12: enc_word = r_fmt(bus.rs, bus.rt, bus.rd, 5'd0, 6'd35);       // SUBU
         6'd13: enc_word = r_fmt(bus.rs, bus.rt, bus.rd, 5'd0, 6'd36);       // AND
         6'd14: enc_word = r_fmt(bus.rs, bus.rt, bus.rd, 5'd0, 6'd37);       // OR
         6'd15: enc_word = r_fmt(bus.rs, bus.rt, bus.rd, 5'd0, 6'd38);       // XOR
         6'd16: enc_word = r_fmt(bus.rs, bus.rt, bus.rd, 5'd0, 6'd39);       // NOR
         6'd17: enc_word = r_fmt(bus.rs, bus.rt, bus.rd, 5'd0, 6'd42);       // SLT
         6'd18: enc_word = r_fmt(bus.rs, bus.rt, bus.rd, 5'd0, 6'd43);       // SLTU
         6'd19: enc_word = i_fmt(6'd1,  bus.rs, 5'd0,  bus.imm);             // BLTZ
         6'd20: enc_word = i_fmt(6'd1,  bus.rs, 5'd1,  bus.imm);             // BGEZ
         6'd21: enc_word = i_fmt(6'd1,  bus.rs, 5'd17, bus.imm);             // BGEZAL
         6'd22: enc_word = {6'd2, bus.target};                               // J
         6'd23: enc_word = {6'd3, bus.target};                               // JAL
         6'd24: enc_word = i_fmt(6'd4,  bus.rs, bus.rt, bus.imm);            // BEQ
         6'd25: enc_word = i_fmt(6'd5,  bus.rs, bus.rt, bus.imm);            // BNE
         6'd26: enc_word = i_fmt(6'd6,  bus.rs, 5'd0,   bus.imm);            // BLEZ
         6'd27: enc_word = i_fmt(6'd7,  bus.rs, 5'd0,   bus.imm);            // BGTZ
         6'd28: enc_word = i_fmt(6'd8,  bus.rs, bus.rt, bus.imm);            // ADDI
         6'd29: enc_word = i_fmt(6'd9,  bus.rs, bus.rt, bus.imm);            // ADDIU
         6'd30: enc_word = i_fmt(6'd10, bus.rs, bus.rt, bus.imm);            // SLTI
         6'd31: enc_word = i_fmt(6'd11, bus.rs, bus.rt, bus.imm);            // SLTIU
         6'd32: enc_word = i_fmt(6'd12, bus.rs, bus.rt, bus.imm);            // ANDI
         6'd33: enc_word = i_fmt(6'd13, bus.rs, bus.rt, bus.imm);            // ORI
         6'd34: enc_word = i_fmt(6'd14, bus.rs, bus.rt, bus.imm);            // XORI
         6'd35: enc_word = i_fmt(6'd15, 5'd0,   bus.rt, bus.imm);            // LUI
         6'd36: enc_word = i_fmt(6'd32, bus.rs, bus.rt, bus.imm);            // LB
         6'd37: enc_word = i_fmt(6'd33, bus.rs, bus.rt, bus.imm);            // LH
         6'd38: enc_word = i_fmt(6'd35, bus.rs, bus.rt, bus.imm);            // LW
         6'd39: enc_word = i_fmt(6'd36, bus.rs, bus.rt, bus.imm);            // LBU
         6'd40: enc_word = i_fmt(6'd37, bus.rs, bus.rt, bus.imm);            // LHU
         6'd41: enc_word = i_fmt(6'd40, bus.rs, bus.rt, bus.imm);            // SB
         6'd42: enc_word = i_fmt(6'd41, bus.rs, bus.rt, bus.imm);            // SH
         6'd43: enc_word = i_fmt(6'd43, bus.rs, bus.rt, bus.imm);            // SW
         default: enc_legal = 1'b0;
      endcase
   end

   // Queue storage; pointers are cleared on flush so stale entries are never read.
   always_ff @(posedge clk) begin
      if (push && !flush) begin
         mem[wr_ptr] <= enc_word;
      end
   end

   // Queue pointers, occupancy, head address and sticky illegal-op capture.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count       <= '0;
         addr_q      <= BASE_ADDR;
         err_illegal <= 1'b0;
         err_op      <= 6'd0;
      end else if (flush) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count       <= '0;
         addr_q      <= BASE_ADDR;
         err_illegal <= 1'b0;
         err_op      <= 6'd0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
            addr_q <= addr_q + 32'd4;
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (accept && !enc_legal) begin
            err_illegal <= 1'b1;
            if (!err_illegal) begin
               err_op <= bus.op_id;
            end
         end
      end
   end

`ifdef ENC_COUNT_EN
   // Saturating count of output handshakes since reset or flush.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         emit_count <= 32'h0;
      end else if (flush) begin
         emit_count <= 32'h0;
      end else if (pop && (emit_count != 32'hFFFF_FFFF)) begin
         emit_count <= emit_count + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_mips_instr_encoder.sv
// Bench for mips_instr_encoder: encoding table, latency, full/backpressure, illegal ops, flush, async reset.
// Expected words come from a hand-computed table and flow through a scoreboard queue with an address model.
// All checking runs in one process: neg() samples at the falling edge, pos() steps to just after the rising edge.
module tb_mips_instr_encoder;
   localparam logic [31:0] BASE = 32'h0000_3000;

   typedef struct {
      logic [5:0]  op;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  rd;
      logic [4:0]  sh;
      logic [15:0] imm;
      logic [25:0] tgt;
      logic [31:0] exp;
   } vec_t;

   logic        clk;
   logic        rst_n;
   logic        flush;
   logic        err_illegal;
   logic [5:0]  err_op;
`ifdef ENC_COUNT_EN
   logic [31:0] emit_count;
`endif

   int          checks;
   int          errors;
   logic [31:0] exp_q[$];
   logic [31:0] exp_addr;
   logic [31:0] cur_exp;
   bit          cur_legal;
   int          n_pops;
   vec_t        tv[16];

   mips_instr_encoder_if bus ();

   mips_instr_encoder #(.FIFO_DEPTH(4), .BASE_ADDR(BASE)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .flush       (flush),
      .bus         (bus),
      .err_illegal (err_illegal),
      .err_op      (err_op)
`ifdef ENC_COUNT_EN
      ,
      .emit_count  (emit_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Scoreboard update for the handshakes that will complete at the coming rising edge.
   task automatic sample();
      logic [31:0] e;
      if (!rst_n) return;
      if (flush) begin
         exp_q.delete();
         exp_addr = BASE;
         n_pops   = 0;
         return;
      end
      if (bus.out_valid && bus.out_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_unexpected_word actual=%h required=none", bus.out_instr);
         end else begin
            e = exp_q.pop_front();
            chk("sb_instr", bus.out_instr, e);
            chk("sb_addr", bus.out_addr, exp_addr);
         end
         exp_addr = exp_addr + 32'd4;
         n_pops++;
      end
      if (bus.in_valid && bus.in_ready && cur_legal) exp_q.push_back(cur_exp);
   endtask

   task automatic neg();
      @(negedge clk);
      sample();
   endtask

   task automatic pos();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [4:0] sh, input logic [15:0] imm,
                        input logic [25:0] tgt, input logic [31:0] exp, input bit legal);
      bus.op_id    = op;
      bus.rs       = rs;
      bus.rt       = rt;
      bus.rd       = rd;
      bus.shamt    = sh;
      bus.imm      = imm;
      bus.target   = tgt;
      cur_exp      = exp;
      cur_legal    = legal;
      bus.in_valid = 1'b1;
   endtask

   task automatic send(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [4:0] sh, input logic [15:0] imm,
                       input logic [25:0] tgt, input logic [31:0] exp, input bit legal);
      bit acc;
      acc = 1'b0;
      drive(op, rs, rt, rd, sh, imm, tgt, exp, legal);
      for (int n = 0; n < 20 && !acc; n++) begin
         neg();
         acc = bus.in_ready;
         pos();
      end
      if (!acc) begin
         checks++;
         errors++;
         $display("FAIL send_timeout actual=in_ready_low required=accept op=%0d", op);
      end
      bus.in_valid = 1'b0;
   endtask

   task automatic send_vec(input int i);
      send(tv[i].op, tv[i].rs, tv[i].rt, tv[i].rd, tv[i].sh, tv[i].imm, tv[i].tgt, tv[i].exp, 1'b1);
   endtask

   task automatic drain();
      for (int k = 0; k < 40 && exp_q.size() != 0; k++) begin
         neg();
         pos();
      end
      chk("drain_queue_left", exp_q.size(), 0);
      neg();
      chk("drain_out_valid", bus.out_valid, 1'b0);
      pos();
   endtask

   initial begin
      //          op     rs     rt     rd     sh     imm       tgt           expected
      tv[0]  = '{6'd10, 5'd1,  5'd2,  5'd3,  5'd0,  16'h0000, 26'h0000000, 32'h00221821}; // ADDU
      tv[1]  = '{6'd1,  5'd31, 5'd1,  5'd2,  5'd4,  16'h0000, 26'h0000000, 32'h00011100}; // SLL
      tv[2]  = '{6'd33, 5'd0,  5'd8,  5'd0,  5'd0,  16'h1234, 26'h0000000, 32'h34081234}; // ORI
      tv[3]  = '{6'd22, 5'd3,  5'd0,  5'd0,  5'd0,  16'h0000, 26'h0100000, 32'h08100000}; // J
      tv[4]  = '{6'd21, 5'd4,  5'd7,  5'd0,  5'd0,  16'hFFFF, 26'h0000000, 32'h0491FFFF}; // BGEZAL
      tv[5]  = '{6'd43, 5'd29, 5'd31, 5'd0,  5'd0,  16'h0004, 26'h0000000, 32'hAFBF0004}; // SW
      tv[6]  = '{6'd7,  5'd31, 5'd5,  5'd6,  5'd7,  16'h0000, 26'h0000000, 32'h03E00008}; // JR
      tv[7]  = '{6'd0,  5'd1,  5'd2,  5'd3,  5'd4,  16'h5555, 26'h0000003, 32'h00000000}; // NOP
      tv[8]  = '{6'd35, 5'd5,  5'd1,  5'd0,  5'd0,  16'hABCD, 26'h0000000, 32'h3C01ABCD}; // LUI
      tv[9]  = '{6'd11, 5'd2,  5'd3,  5'd4,  5'd9,  16'h0000, 26'h0000000, 32'h00432022}; // SUB
      tv[10] = '{6'd26, 5'd6,  5'd9,  5'd0,  5'd0,  16'h0010, 26'h0000000, 32'h18C00010}; // BLEZ
      tv[11] = '{6'd8,  5'd3,  5'd4,  5'd31, 5'd2,  16'h0000, 26'h0000000, 32'h0060F809}; // JALR
      tv[12] = '{6'd6,  5'd1,  5'd2,  5'd3,  5'd5,  16'h0000, 26'h0000000, 32'h00221807}; // SRAV
      tv[13] = '{6'd23, 5'd0,  5'd0,  5'd0,  5'd0,  16'h0000, 26'h3FFFFFF, 32'h0FFFFFFF}; // JAL
      tv[14] = '{6'd19, 5'd2,  5'd31, 5'd0,  5'd0,  16'h8000, 26'h0000000, 32'h04408000}; // BLTZ
      tv[15] = '{6'd39, 5'd4,  5'd5,  5'd0,  5'd0,  16'hFFF0, 26'h0000000, 32'h9085FFF0}; // LBU

      checks = 0; errors = 0; n_pops = 0;
      exp_addr = BASE; cur_exp = 32'h0; cur_legal = 1'b0;
      rst_n = 1'b0; flush = 1'b0;
      bus.in_valid = 1'b0; bus.out_ready = 1'b0;
      bus.op_id = 6'd0; bus.rs = 5'd0; bus.rt = 5'd0; bus.rd = 5'd0;
      bus.shamt = 5'd0; bus.imm = 16'h0; bus.target = 26'h0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      // Reset state
      neg();
      chk("rst_in_ready", bus.in_ready, 1'b1);
      chk("rst_out_valid", bus.out_valid, 1'b0);
      chk("rst_out_instr", bus.out_instr, 32'h0);
      chk("rst_out_addr", bus.out_addr, BASE);
      chk("rst_err_illegal", err_illegal, 1'b0);
      chk("rst_err_op", err_op, 6'd0);
`ifdef ENC_COUNT_EN
      chk("rst_emit_count", emit_count, 32'h0);
`endif
      pos();

      // T1: one-cycle latency, no combinational path
      bus.out_ready = 1'b1;
      drive(tv[0].op, tv[0].rs, tv[0].rt, tv[0].rd, tv[0].sh, tv[0].imm, tv[0].tgt, tv[0].exp, 1'b1);
      neg();
      chk("t1_no_comb_path", bus.out_valid, 1'b0);
      pos();
      bus.in_valid = 1'b0;
      neg();
      chk("t1_valid_next", bus.out_valid, 1'b1);
      chk("t1_instr", bus.out_instr, 32'h00221821);
      chk("t1_addr", bus.out_addr, 32'h00003000);
      pos();
      drain();

      // Encoding table with intermittent sink stalls
      for (int i = 0; i < 16; i++) begin
         bus.out_ready = (i % 3 != 2);
         send_vec(i);
      end
      bus.out_ready = 1'b1;
      drain();
`ifdef ENC_COUNT_EN
      chk("emit_count_table", emit_count, n_pops);
`endif

      // T4: fill, hold the 5th, single pop lets it in one cycle later
      bus.out_ready = 1'b0;
      for (int i = 0; i < 4; i++) send_vec(i);
      drive(tv[4].op, tv[4].rs, tv[4].rt, tv[4].rd, tv[4].sh, tv[4].imm, tv[4].tgt, tv[4].exp, 1'b1);
      neg();
      chk("t4_full_ready", bus.in_ready, 1'b0);
      chk("t4_full_valid", bus.out_valid, 1'b1);
      pos();
      bus.out_ready = 1'b1;
      neg();
      chk("t4_no_push_through", bus.in_ready, 1'b0);
      pos();
      bus.out_ready = 1'b0;
      neg();
      chk("t4_ready_rises", bus.in_ready, 1'b1);
      pos();
      bus.in_valid = 1'b0;
      neg();
      chk("t4_full_again", bus.in_ready, 1'b0);
      pos();
      bus.out_ready = 1'b1;
      drain();

      // T5: illegal op mid-stream, sticky error keeps first op, then flush
      send_vec(5);
      send(6'd50, 5'd1, 5'd2, 5'd3, 5'd4, 16'h1111, 26'h0, 32'h0, 1'b0);
      send_vec(6);
      send(6'd60, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0, 32'h0, 1'b0);
      drain();
      chk("t5_err_illegal", err_illegal, 1'b1);
      chk("t5_err_op", err_op, 6'd50);
      bus.out_ready = 1'b0;
      send_vec(7);
      send_vec(8);
      drive(tv[9].op, tv[9].rs, tv[9].rt, tv[9].rd, tv[9].sh, tv[9].imm, tv[9].tgt, tv[9].exp, 1'b1);
      flush = 1'b1;
      neg();
      pos();
      flush = 1'b0;
      bus.in_valid = 1'b0;
      neg();
      chk("t5_flush_out_valid", bus.out_valid, 1'b0);
      chk("t5_flush_err_illegal", err_illegal, 1'b0);
      chk("t5_flush_err_op", err_op, 6'd0);
      chk("t5_flush_out_addr", bus.out_addr, BASE);
`ifdef ENC_COUNT_EN
      chk("t5_flush_emit_count", emit_count, 32'h0);
`endif
      pos();
      bus.out_ready = 1'b1;
      send_vec(10);
      drain();

      // T6: asynchronous reset with words queued
      bus.out_ready = 1'b0;
      send_vec(11);
      send_vec(12);
      send_vec(13);
      #2 rst_n = 1'b0;
      #1;
      chk("t6_rst_out_valid", bus.out_valid, 1'b0);
      chk("t6_rst_out_addr", bus.out_addr, BASE);
      chk("t6_rst_out_instr", bus.out_instr, 32'h0);
`ifdef ENC_COUNT_EN
      chk("t6_rst_emit_count", emit_count, 32'h0);
`endif
      exp_q.delete();
      exp_addr = BASE;
      n_pops = 0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      neg();
      chk("t6_after_rst_valid", bus.out_valid, 1'b0);
      chk("t6_after_rst_ready", bus.in_ready, 1'b1);
      pos();
      bus.out_ready = 1'b1;
      send_vec(14);
      send_vec(15);
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
